ss_ddr_bridge: RTL and testbench
================================

# ss_ddr_bridge

Converts the savestate engine's toggle-handshake DDR port (64-bit words, 19-bit word address, byte enables) into single-beat Avalon-MM transactions on the MiSTer DDRAM port. It sits directly downstream of the savestate controller and upstream of the DDRAM arbiter. It adds a one-entry sequential read-ahead buffer so that streamed savestate loads see one-cycle hits instead of full DDR latency.

## Interface
Parameters:
- SS_BASE, 29'h07C00000: DDRAM word base. Only bits [28:19] are used.
- PREFETCH, 1: enables the read-ahead buffer. When 0, every read goes to DDR.

Ports (clock and reset first):
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; clock is clk
- ss_req  in  1  request toggle; a new request is pending when ss_req != ss_ack
- ss_ack  out  1  acknowledge toggle; set equal to ss_req on completion
- ss_addr  in  19  word address [21:3], stable while pending
- ss_we  in  1  1 = write, 0 = read
- ss_be  in  8  write byte enables
- ss_wdata  in  64  write data
- ss_rdata  out  64  read data; held until the next read completes
- pf_flush  in  1  one-cycle pulse that invalidates the read-ahead buffer
- ddram_busy  in  1  Avalon waitrequest
- ddram_addr  out  29  {SS_BASE[28:19], addr}
- ddram_burstcnt  out  8  constant 1
- ddram_rd  out  1  read strobe
- ddram_we  out  1  write strobe
- ddram_din  out  64  write data
- ddram_be  out  8  byte enables
- ddram_dout  in  64  read data
- ddram_dout_ready  in  1  read data valid

## Operation
- Reset values:
  - ss_ack=0, ss_rdata=0.
  - ddram_rd=0, ddram_we=0, ddram_addr=0, ddram_din=0, ddram_be=8'hFF, ddram_burstcnt=1.
  - pf_valid=0, state IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, PF_ISSUE, PF_WAIT.
- IDLE with a pending request:
  - Write: latch address, data and byte enables, then go to WR_ISSUE. If pf_valid and pf_addr==ss_addr, clear pf_valid.
  - Read hit (pf_valid, pf_addr==ss_addr): ss_rdata<=pf_data, toggle ss_ack, clear pf_valid. Then, if PREFETCH is set and ss_addr != 19'h7FFFF, go to PF_ISSUE for ss_addr+1; otherwise stay in IDLE.
  - Read miss: go to RD_ISSUE.
- RD_ISSUE / WR_ISSUE / PF_ISSUE:
  - Strobe is asserted and held with address and data stable until an edge where ddram_busy=0.
  - Then RD→RD_WAIT, PF→PF_WAIT. WR toggles ss_ack, drops ddram_we and returns to IDLE.
- RD_WAIT:
  - On ddram_dout_ready: ss_rdata<=ddram_dout and toggle ss_ack.
  - Then go to PF_ISSUE for addr+1 if PREFETCH is set and addr != 19'h7FFFF (no wrap-around prefetch); otherwise go to IDLE.
- PF_WAIT:
  - On ddram_dout_ready: pf_data<=ddram_dout, pf_valid<=~pf_discard, then go to IDLE.
  - A request arriving during PF_ISSUE/PF_WAIT is not serviced until return to IDLE, because an Avalon read cannot be aborted.
- pf_flush:
  - Clears pf_valid in any state.
  - In PF_ISSUE/PF_WAIT it sets pf_discard so the in-flight word is dropped. pf_discard clears on entry to PF_ISSUE.
- ddram_dout_ready outside RD_WAIT/PF_WAIT is ignored. This covers data left outstanding when reset is asserted mid-read.
- Only one request is ever outstanding; no queueing.

## Timing
- Request detection is registered. A request visible at edge N is decoded at N.
- Read hit: ss_rdata and ss_ack change at edge N+1 (1-cycle latency).
- Read miss: ddram_rd is high from N+1. ss_ack toggles on the edge that samples ddram_dout_ready, so ss_rdata and ss_ack change together.
- Write: ddram_we is high from N+1. ss_ack toggles on the first edge with ddram_busy=0 and ddram_we=1.
- Prefetch issue begins the cycle after the ack toggle.
- Reset asserted mid-operation: immediate return to reset values. A subsequent stale dout_ready is ignored.

## Structure
- Shared package ss_pkg:
  - state enum ss_bridge_state_t
  - SS_WORD_AW=19, DDRAM_AW=29
  - default SS_BASE
- One sub-module is natural: ss_prefetch_buf. It holds pf_valid, pf_addr, pf_data and pf_discard, with a hit compare, invalidate, flush and fill interface.
- The FSM and Avalon drive stay in the top level.

## Test plan
- Write addr 0x00001, be 0xF0, data 0x1122334455667788, busy high for 3 cycles → ddram_we held 4 cycles at ddram_addr 0x07C00001, ss_ack toggles on the accept edge.
- Read miss at 0x00008, dout 0xA5A5…, 5-cycle latency → ss_rdata=0xA5A5…, ack toggle, then a prefetch read of 0x00009 is issued.
- Read of 0x00009 after the prefetch fill → no ddram_rd, data returned one cycle after the request, and a prefetch of 0x0000A is issued.
- Read 0x7FFFF → no prefetch issued; state returns to IDLE.
- Write 0x0000A while pf_addr=0x0000A is valid, then read 0x0000A → DDR read issued (the write invalidated the buffer).
- pf_flush during PF_WAIT, then a read of the prefetched address → a miss, and the fresh DDR read is issued. Separately, assert reset mid-RD_WAIT then pulse dout_ready → no ack and no state change.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for the savestate DDR bridge: FSM state type, address
// widths and the default DDRAM window base.
package ss_pkg;
  localparam int SS_WORD_AW = 19;
  localparam int DDRAM_AW   = 29;

  localparam logic [DDRAM_AW-1:0]   SS_BASE_DEFAULT = 29'h07C00000;
  localparam logic [SS_WORD_AW-1:0] SS_ADDR_LAST    = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    PF_ISSUE,
    PF_WAIT
  } ss_bridge_state_t;
endpackage

// File: rtl/ss_prefetch_buf.sv
// One-entry read-ahead buffer for the savestate DDR bridge.
// Ports:
//   clk, reset_n            clock / async active-low reset
//   lookup_addr -> hit      combinational hit compare against the held word
//   pf_data                 held word
//   inval                   drop the entry (consumed read hit or write to it)
//   flush, in_flight        external flush; while a prefetch is in flight it
//                           also marks the returning word for discard
//   arm, arm_addr           a new prefetch is being issued for arm_addr
//   fill, fill_data         prefetch read data returned
module ss_prefetch_buf
  import ss_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SS_WORD_AW-1:0] lookup_addr,
  output logic                  hit,
  output logic [63:0]           pf_data,
  input  logic                  inval,
  input  logic                  flush,
  input  logic                  in_flight,
  input  logic                  arm,
  input  logic [SS_WORD_AW-1:0] arm_addr,
  input  logic                  fill,
  input  logic [63:0]           fill_data
);
  logic                  pf_valid_q,   pf_valid_d;
  logic                  pf_discard_q, pf_discard_d;
  logic [SS_WORD_AW-1:0] pf_addr_q,    pf_addr_d;
  logic [63:0]           pf_data_q,    pf_data_d;

  assign hit     = pf_valid_q && (pf_addr_q == lookup_addr);
  assign pf_data = pf_data_q;

  always_comb begin
    pf_valid_d   = pf_valid_q;
    pf_discard_d = pf_discard_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    // Arming replaces the entry, so the old word is no longer valid.
    if (arm) begin
      pf_addr_d    = arm_addr;
      pf_valid_d   = 1'b0;
      pf_discard_d = 1'b0;
    end
    if (fill) begin
      pf_data_d  = fill_data;
      pf_valid_d = ~pf_discard_q;
    end
    if (inval) pf_valid_d = 1'b0;
    // Flush wins over a same-cycle fill.
    if (flush) begin
      pf_valid_d = 1'b0;
      if (in_flight) pf_discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_valid_q   <= 1'b0;
      pf_discard_q <= 1'b0;
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
    end else begin
      pf_valid_q   <= pf_valid_d;
      pf_discard_q <= pf_discard_d;
      pf_addr_q    <= pf_addr_d;
      pf_data_q    <= pf_data_d;
    end
  end
endmodule

// File: rtl/ss_ddr_bridge.sv
// Savestate toggle-handshake port to single-beat Avalon-MM DDRAM bridge with
// a one-entry sequential read-ahead buffer.
// Ports:
//   clk, reset_n                      clock / async active-low reset
//   ss_req/ss_ack                     toggle handshake (pending when unequal)
//   ss_addr/ss_we/ss_be/ss_wdata      request; ss_rdata holds last read data
//   pf_flush                          invalidate the read-ahead buffer
//   ddram_*                           Avalon-MM master, burstcount fixed at 1
module ss_ddr_bridge
  import ss_pkg::*;
#(
  parameter logic [DDRAM_AW-1:0] SS_BASE  = SS_BASE_DEFAULT,
  parameter bit                  PREFETCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ss_req,
  output logic                  ss_ack,
  input  logic [SS_WORD_AW-1:0] ss_addr,
  input  logic                  ss_we,
  input  logic [7:0]            ss_be,
  input  logic [63:0]           ss_wdata,
  output logic [63:0]           ss_rdata,
  input  logic                  pf_flush,
  input  logic                  ddram_busy,
  output logic [DDRAM_AW-1:0]   ddram_addr,
  output logic [7:0]            ddram_burstcnt,
  output logic                  ddram_rd,
  output logic                  ddram_we,
  output logic [63:0]           ddram_din,
  output logic [7:0]            ddram_be,
  input  logic [63:0]           ddram_dout,
  input  logic                  ddram_dout_ready
);
  localparam logic [DDRAM_AW-SS_WORD_AW-1:0] BASE_HI = SS_BASE[DDRAM_AW-1:SS_WORD_AW];

  ss_bridge_state_t      state_q, state_d;
  logic                  req_q, ack_q, ack_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rd_q, rd_d, we_q, we_d;
  logic [DDRAM_AW-1:0]   addr_q, addr_d;
  logic [63:0]           din_q, din_d;
  logic [7:0]            be_q, be_d;

  logic                  pending, buf_hit, pf_hit;
  logic [63:0]           buf_data;
  logic                  pf_inval, pf_arm, pf_fill, pf_in_flight;
  logic [SS_WORD_AW-1:0] pf_arm_addr, cur_addr;

  // The request toggle is registered before comparison with ack.
  assign pending      = req_q != ack_q;
  assign pf_hit       = PREFETCH && buf_hit;
  assign cur_addr     = addr_q[SS_WORD_AW-1:0];
  assign pf_in_flight = (state_q == PF_ISSUE) || (state_q == PF_WAIT);

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    we_d        = we_q;
    addr_d      = addr_q;
    din_d       = din_q;
    be_d        = be_q;
    pf_inval    = 1'b0;
    pf_arm      = 1'b0;
    pf_arm_addr = '0;
    pf_fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          if (ss_we) begin
            addr_d   = {BASE_HI, ss_addr};
            din_d    = ss_wdata;
            be_d     = ss_be;
            we_d     = 1'b1;
            pf_inval = pf_hit;
            state_d  = WR_ISSUE;
          end else if (pf_hit) begin
            rdata_d  = buf_data;
            ack_d    = ~ack_q;
            pf_inval = 1'b1;
            if (PREFETCH && ss_addr != SS_ADDR_LAST) begin
              pf_arm      = 1'b1;
              pf_arm_addr = ss_addr + 19'd1;
            end
          end else begin
            addr_d  = {BASE_HI, ss_addr};
            be_d    = 8'hFF;
            rd_d    = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: if (!ddram_busy) begin rd_d = 1'b0; state_d = RD_WAIT; end
      PF_ISSUE: if (!ddram_busy) begin rd_d = 1'b0; state_d = PF_WAIT; end
      WR_ISSUE: begin
        if (!ddram_busy) begin
          we_d    = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (ddram_dout_ready) begin
          rdata_d = ddram_dout;
          ack_d   = ~ack_q;
          state_d = IDLE;
          // No wrap-around read-ahead past the top of the window.
          if (PREFETCH && cur_addr != SS_ADDR_LAST) begin
            pf_arm      = 1'b1;
            pf_arm_addr = cur_addr + 19'd1;
          end
        end
      end
      PF_WAIT: begin
        if (ddram_dout_ready) begin
          pf_fill = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Prefetch issue shares the ack edge, so ddram_rd rises the cycle after.
    if (pf_arm) begin
      addr_d  = {BASE_HI, pf_arm_addr};
      be_d    = 8'hFF;
      rd_d    = 1'b1;
      state_d = PF_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      req_q   <= ss_req;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
    end
  end

  ss_prefetch_buf u_pf (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_addr (ss_addr),
    .hit         (buf_hit),
    .pf_data     (buf_data),
    .inval       (pf_inval),
    .flush       (pf_flush),
    .in_flight   (pf_in_flight),
    .arm         (pf_arm),
    .arm_addr    (pf_arm_addr),
    .fill        (pf_fill),
    .fill_data   (ddram_dout)
  );

  assign ss_ack         = ack_q;
  assign ss_rdata       = rdata_q;
  assign ddram_addr     = addr_q;
  assign ddram_burstcnt = 8'd1;
  assign ddram_rd       = rd_q;
  assign ddram_we       = we_q;
  assign ddram_din      = din_q;
  assign ddram_be       = be_q;
endmodule

// File: tb/tb_ss_ddr_bridge.sv
module tb_ss_ddr_bridge;
  import ss_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        ss_req = 1'b0, ss_we = 1'b0, ss_ack;
  logic [18:0] ss_addr = '0;
  logic [7:0]  ss_be = '0;
  logic [63:0] ss_wdata = '0, ss_rdata;
  logic        pf_flush = 1'b0, ddram_busy = 1'b0;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic        ddram_rd, ddram_we;
  logic [63:0] ddram_din, ddram_dout = '0;
  logic        m_rdy = 1'b0, inj_rdy = 1'b0, ddram_dout_ready;
  assign ddram_dout_ready = m_rdy | inj_rdy;

  ss_ddr_bridge dut (
    .clk(clk), .reset_n(reset_n), .ss_req(ss_req), .ss_ack(ss_ack),
    .ss_addr(ss_addr), .ss_we(ss_we), .ss_be(ss_be), .ss_wdata(ss_wdata),
    .ss_rdata(ss_rdata), .pf_flush(pf_flush), .ddram_busy(ddram_busy),
    .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd),
    .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [63:0] exp_q[$];

  // DDR slave model: storage, busy stretch per transaction, fixed read latency.
  logic [63:0] mem [logic [18:0]];
  logic [18:0] rd_log[$];
  int          busy_cfg = 0, busy_left = 0, rd_lat = 3, resp_cnt = 0;
  logic [18:0] resp_addr = '0;
  logic [63:0] wtmp;

  function automatic logic [63:0] mem_rd(input logic [18:0] a);
    if (mem.exists(a)) return mem[a];
    return {13'h0, a, 13'h1, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    m_rdy = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin m_rdy = 1'b1; ddram_dout = mem_rd(resp_addr); end
    end
    ddram_busy = 1'b0;
    if (ddram_rd || ddram_we) begin
      if (busy_left > 0) begin
        ddram_busy = 1'b1;
        busy_left--;
      end else begin
        busy_left = busy_cfg;
        if (ddram_we) begin
          wtmp = mem_rd(ddram_addr[18:0]);
          for (int b = 0; b < 8; b++) if (ddram_be[b]) wtmp[b*8 +: 8] = ddram_din[b*8 +: 8];
          mem[ddram_addr[18:0]] = wtmp;
        end else begin
          rd_log.push_back(ddram_addr[18:0]);
          resp_addr = ddram_addr[18:0];
          resp_cnt  = rd_lat;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_busy(input int n);
    busy_cfg = n; busy_left = n;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  logic [28:0] cap_addr;
  logic [63:0] cap_din;
  logic [7:0]  cap_be;

  // Issue one request; cyc = negedges until ack seen, stb = strobe cycles before ack.
  task automatic do_req(input logic we, input logic [18:0] a, input logic [7:0] be,
                        input logic [63:0] wd, input logic [63:0] exp_rd,
                        output int cyc, output int stb);
    logic done;
    @(negedge clk);
    if (!we) exp_q.push_back(exp_rd);
    ss_we = we; ss_addr = a; ss_be = be; ss_wdata = wd;
    ss_req = ~ss_req;
    cyc = 0; stb = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ss_ack === ss_req) done = 1'b1;
      else if (ddram_rd || ddram_we) begin
        stb++; cap_addr = ddram_addr; cap_din = ddram_din; cap_be = ddram_be;
      end
    end
    chk("ack_timeout", {63'd0, done}, 64'd1);
    if (!we) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 64'd1, 64'd0);
      else chk("rdata", ss_rdata, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, stb, rl0;
    logic [63:0] exp_a;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_ack", {63'd0, ss_ack}, 64'd0);
    chk("rst_rdata", ss_rdata, 64'd0);
    chk("rst_rd", {63'd0, ddram_rd}, 64'd0);
    chk("rst_we", {63'd0, ddram_we}, 64'd0);
    chk("rst_addr", {35'd0, ddram_addr}, 64'd0);
    chk("rst_din", ddram_din, 64'd0);
    chk("rst_be", {56'd0, ddram_be}, 64'hFF);
    chk("rst_burst", {56'd0, ddram_burstcnt}, 64'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write with 3 busy cycles.
    set_busy(3);
    do_req(1'b1, 19'h00001, 8'hF0, 64'h1122334455667788, '0, cyc, stb);
    chk("wr_we_cycles", 64'(stb), 64'd4);
    chk("wr_ack_cycle", 64'(cyc), 64'd6);
    chk("wr_addr", {35'd0, cap_addr}, 64'h07C00001);
    chk("wr_be", {56'd0, cap_be}, 64'hF0);
    chk("wr_din", cap_din, 64'h1122334455667788);
    set_busy(0);
    settle();

    // Read miss then prefetch of the next word.
    mem[19'h00008] = 64'hA5A5A5A5A5A5A5A5;
    rd_lat = 5;
    rl0 = rd_log.size();
    do_req(1'b0, 19'h00008, 8'h00, '0, 64'hA5A5A5A5A5A5A5A5, cyc, stb);
    chk("miss_rd_cycles", 64'(stb), 64'd1);
    settle();
    chk("miss_rd_count", 64'(rd_log.size()), 64'(rl0 + 2));
    chk("miss_rd_addr", {45'd0, rd_log[rl0]}, 64'h8);
    chk("miss_pf_addr", {45'd0, rd_log[rl0 + 1]}, 64'h9);

    // Hit on the prefetched word: one-cycle, no DDR read, next prefetch issued.
    rl0 = rd_log.size();
    do_req(1'b0, 19'h00009, 8'h00, '0, mem_rd(19'h00009), cyc, stb);
    chk("hit_latency", 64'(cyc), 64'd2);
    chk("hit_no_rd", 64'(stb), 64'd0);
    settle();
    chk("hit_rd_count", 64'(rd_log.size()), 64'(rl0 + 1));
    chk("hit_pf_addr", {45'd0, rd_log[rl0]}, 64'hA);

    // Write to the buffered address invalidates it; the following read goes to DDR.
    exp_a = merge(mem_rd(19'h0000A), 64'hDEADBEEFCAFEF00D, 8'h0F);
    do_req(1'b1, 19'h0000A, 8'h0F, 64'hDEADBEEFCAFEF00D, '0, cyc, stb);
    settle();
    rl0 = rd_log.size();
    do_req(1'b0, 19'h0000A, 8'h00, '0, exp_a, cyc, stb);
    chk("inval_rd_cycles", 64'(stb), 64'd1);
    settle();
    chk("inval_rd_addr", {45'd0, rd_log[rl0]}, 64'hA);

    // Top of window: no prefetch.
    rl0 = rd_log.size();
    do_req(1'b0, 19'h7FFFF, 8'h00, '0, mem_rd(19'h7FFFF), cyc, stb);
    settle();
    chk("top_rd_count", 64'(rd_log.size()), 64'(rl0 + 1));
    chk("top_rd_idle", {63'd0, ddram_rd}, 64'd0);

    // Flush while the prefetch is in flight: the prefetched address misses.
    rd_lat = 6;
    do_req(1'b0, 19'h00100, 8'h00, '0, mem_rd(19'h00100), cyc, stb);
    @(negedge clk); pf_flush = 1'b1;
    @(negedge clk); pf_flush = 1'b0;
    settle();
    rl0 = rd_log.size();
    chk("flush_pf_issued", {45'd0, rd_log[rl0 - 1]}, 64'h101);
    do_req(1'b0, 19'h00101, 8'h00, '0, mem_rd(19'h00101), cyc, stb);
    chk("flush_miss_rd", 64'(stb), 64'd1);
    settle();
    chk("flush_miss_addr", {45'd0, rd_log[rl0]}, 64'h101);

    // Reset in RD_WAIT; late and injected dout_ready are ignored.
    rd_lat = 8;
    @(negedge clk);
    ss_we = 1'b0; ss_addr = 19'h00200; ss_req = ~ss_req;
    repeat (4) @(negedge clk);
    reset_n = 1'b0; ss_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    inj_rdy = 1'b1;
    @(negedge clk); inj_rdy = 1'b0;
    settle();
    chk("rstmid_ack", {63'd0, ss_ack}, 64'd0);
    chk("rstmid_rdata", ss_rdata, 64'd0);
    chk("rstmid_rd", {63'd0, ddram_rd}, 64'd0);
    chk("rstmid_addr", {35'd0, ddram_addr}, 64'd0);
    chk("rstmid_be", {56'd0, ddram_be}, 64'hFF);

    // Normal operation resumes.
    rd_lat = 3;
    do_req(1'b0, 19'h00300, 8'h00, '0, mem_rd(19'h00300), cyc, stb);
    chk("post_rst_rd", 64'(stb), 64'd1);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
